hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 84 ++++++++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

    // Controller operating modes: normal issue, draining after halt, stopped
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int NREG_DEFAULT         = 16;
    localparam int DRAIN_CYCLES_DEFAULT = 3;

    // Pending-write counter per register; saturates at CNT_MAX
    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_MAX  = 2'd3;
    localparam cnt_t CNT_ZERO = 2'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write counters with busy lookup
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int  NREG = NREG_DEFAULT,
    localparam int IW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [IW-1:0] rd1,
    input  logic [IW-1:0] rd2,
    input  logic          we1,
    input  logic          we2,
    input  logic [IW-1:0] wb_rd1,
    input  logic [IW-1:0] wb_rd2,
    input  logic          wb_we1,
    input  logic          wb_we2,
    input  logic [IW-1:0] rs1,
    input  logic [IW-1:0] rs2,
    output logic          busy1,
    output logic          busy2,
    output logic          all_clear,
    output logic          sb_err
);

    cnt_t            cnt [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;

    // Decode issue and writeback into one-hot inc/dec masks; equal indices collapse to one event
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc[i] = issue & ((we1 & (rd1 == IW'(i))) | (we2 & (rd2 == IW'(i))));
            dec[i] = (wb_we1 & (wb_rd1 == IW'(i))) | (wb_we2 & (wb_rd2 == IW'(i)));
        end
    end

    // Counter update: simultaneous inc and dec cancel; saturating ends hold and raise the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= CNT_ZERO;
            end
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case ({inc[i], dec[i]})
                    2'b10: begin
                        if (cnt[i] == CNT_MAX) begin
                            sb_err <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 2'd1;
                        end
                    end
                    2'b01: begin
                        if (cnt[i] == CNT_ZERO) begin
                            sb_err <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] - 2'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Busy lookup on registered counts; no writeback bypass into this cycle
    always_comb begin
        busy1     = (cnt[rs1] != CNT_ZERO);
        busy2     = (cnt[rs2] != CNT_ZERO);
        all_clear = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (cnt[i] != CNT_ZERO) begin
                all_clear = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW interlock, branch flush and halt drain control for a 5-stage pipe
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int  NREG         = NREG_DEFAULT,
    parameter int  DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    localparam int IW           = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [IW-1:0] id_rs1,
    input  logic [IW-1:0] id_rs2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic [IW-1:0] id_rd1,
    input  logic [IW-1:0] id_rd2,
    input  logic          id_we1,
    input  logic          id_we2,
    input  logic          id_halt,
    input  logic          ex_branch_taken,
    input  logic [IW-1:0] wb_rd1,
    input  logic [IW-1:0] wb_rd2,
    input  logic          wb_we1,
    input  logic          wb_we2,
    output logic          pc_we,
    output logic          ifid_we,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          stall,
    output logic          halted,
    output logic          sb_err
);

    localparam int        DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          busy1;
    logic          busy2;
    logic          all_clear;
    logic          hazard;
    logic          issue;
    logic          halt_issue;

    // A halt occupies an issue slot but never claims a destination register
    reg_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .rd1       (id_rd1),
        .rd2       (id_rd2),
        .we1       (id_we1 & ~id_halt),
        .we2       (id_we2 & ~id_halt),
        .wb_rd1    (wb_rd1),
        .wb_rd2    (wb_rd2),
        .wb_we1    (wb_we1),
        .wb_we2    (wb_we2),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .busy1     (busy1),
        .busy2     (busy2),
        .all_clear (all_clear),
        .sb_err    (sb_err)
    );

    assign hazard     = id_valid & ((id_use1 & busy1) | (id_use2 & busy2));
    assign issue      = id_valid & ~idex_bubble;
    assign halt_issue = issue & id_halt;

    // Output decode: reset and non-RUN states freeze fetch and inject NOPs; in RUN a taken branch beats the interlock
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        stall       = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        stall       = 1'b0;
                    end else if (hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        ifid_flush  = 1'b0;
                        idex_bubble = 1'b1;
                        stall       = 1'b1;
                    end else begin
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b0;
                        idex_bubble = 1'b0;
                        stall       = 1'b0;
                    end
                end
                default: begin
                    stall = hazard;
                end
            endcase
        end
    end

    // Halt FSM: drain counter saturates at its last value until the scoreboard empties
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            halted <= (state == HALTED);
            case (state)
                RUN: begin
                    if (halt_issue) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if ((drain_cnt == DRAIN_LAST) && all_clear) begin
                        state <= HALTED;
                    end else if (drain_cnt != DRAIN_LAST) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
